// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester handshakes and external memory bus pins of
// mem_bus_arbiter, grouped in one bundle.
//   slave  : arbiter view (takes requests and bus read data, drives acks and the bus)
//   master : environment view (cpu fetcher/executor and the memory device)
interface mem_bus_arbiter_if #(
    parameter int BITS = 8
);
    // Instruction-fetch (ROM) requester
    logic            f_req;
    logic [BITS-1:0] f_addr;
    logic            f_ack;
    logic [BITS-1:0] f_rdata;

    // Data (RAM load/store) requester
    logic            d_req;
    logic            d_we;
    logic [BITS-1:0] d_addr;
    logic [BITS-1:0] d_wdata;
    logic            d_ack;
    logic [BITS-1:0] d_rdata;

    // External multiplexed bus
    logic [BITS-1:0] bus_in;
    logic            bus_ready;
    logic [BITS-1:0] bus_out;
    logic            bus_rom_ram;
    logic            bus_addr_data;
    logic            bus_we;
    logic            busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, bus_in, bus_ready,
        output f_ack, f_rdata, d_ack, d_rdata, bus_out, bus_rom_ram, bus_addr_data,
               bus_we, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, bus_in, bus_ready,
        input  f_ack, f_rdata, d_ack, d_rdata, bus_out, bus_rom_ram, bus_addr_data,
               bus_we, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the cpu's single multiplexed ROM/RAM bus between the
// instruction-fetch port and the data port. Every transfer is one address
// phase, a data phase of at least MIN_WAIT+1 cycles ended by bus_ready, and a
// one-cycle ack back to the winner. All outputs come straight from flops; the
// output logic is evaluated against the state being entered.
// Optional feature macro: MEM_BUS_ARB_RR_EN selects round-robin arbitration;
// without it the data port has fixed priority over fetch.
module mem_bus_arbiter #(
    parameter int          BITS     = 8,
    parameter int unsigned MIN_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MIN_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    // Request fields latched in IDLE; port 1 = data, 0 = fetch
    logic [BITS-1:0] addr_r;
    logic [BITS-1:0] addr_nx_s;
    logic [BITS-1:0] wdata_r;
    logic [BITS-1:0] wdata_nx_s;
    logic            we_r;
    logic            we_nx_s;
    logic            port_r;
    logic            port_nx_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nx_s;
    logic            win_data_s;

`ifdef MEM_BUS_ARB_RR_EN
    logic            grant_r;
`endif

    // Registered outputs and their next values
    logic [BITS-1:0] bus_out_r;
    logic [BITS-1:0] bus_out_s;
    logic [BITS-1:0] f_rdata_r;
    logic [BITS-1:0] f_rdata_s;
    logic [BITS-1:0] d_rdata_r;
    logic [BITS-1:0] d_rdata_s;
    logic            rom_ram_r;
    logic            rom_ram_s;
    logic            addr_data_r;
    logic            addr_data_s;
    logic            bus_we_r;
    logic            bus_we_s;
    logic            busy_r;
    logic            busy_s;
    logic            f_ack_r;
    logic            f_ack_s;
    logic            d_ack_r;
    logic            d_ack_s;

    // Choose which of the presented requests wins (1 = data port).
    always_comb begin
`ifdef MEM_BUS_ARB_RR_EN
        if (bus.f_req && bus.d_req) begin
            win_data_s = ~grant_r;
        end else begin
            win_data_s = bus.d_req;
        end
`else
        win_data_s = bus.d_req;
`endif
    end

    // Next state, latched request fields and wait counter.
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        wdata_nx_s = wdata_r;
        we_nx_s    = we_r;
        port_nx_s  = port_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    state_nx_s = ST_ADDR;
                    port_nx_s  = win_data_s;
                    if (win_data_s) begin
                        addr_nx_s  = bus.d_addr;
                        we_nx_s    = bus.d_we;
                        wdata_nx_s = bus.d_wdata;
                    end else begin
                        addr_nx_s  = bus.f_addr;
                        we_nx_s    = 1'b0;
                        wdata_nx_s = {BITS{1'b0}};
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_nx_s = ST_DATA;
                cnt_nx_s   = 4'd0;
            end
            ST_DATA: begin
                if (cnt_r == WAIT_LIMIT) begin
                    if (bus.bus_ready) begin
                        state_nx_s = ST_ACK;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 4'd1;
                end
            end
            ST_ACK: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered at the next edge.
    always_comb begin
        bus_out_s   = {BITS{1'b0}};
        rom_ram_s   = 1'b0;
        addr_data_s = 1'b0;
        bus_we_s    = 1'b0;
        busy_s      = 1'b0;
        f_ack_s     = 1'b0;
        d_ack_s     = 1'b0;
        f_rdata_s   = f_rdata_r;
        d_rdata_s   = d_rdata_r;
        case (state_nx_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_ADDR: begin
                bus_out_s = addr_nx_s;
                rom_ram_s = port_nx_s;
                busy_s    = 1'b1;
            end
            ST_DATA: begin
                addr_data_s = 1'b1;
                rom_ram_s   = port_nx_s;
                busy_s      = 1'b1;
                if (we_nx_s) begin
                    bus_out_s = wdata_nx_s;
                    bus_we_s  = 1'b1;
                end else begin
                    bus_out_s = {BITS{1'b0}};
                    bus_we_s  = 1'b0;
                end
            end
            ST_ACK: begin
                rom_ram_s = port_nx_s;
                busy_s    = 1'b1;
                // ACK is only ever entered from DATA, so this is the capture point
                if (port_nx_s) begin
                    d_ack_s = 1'b1;
                    if (!we_nx_s) begin
                        d_rdata_s = bus.bus_in;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end else begin
                    f_ack_s   = 1'b1;
                    f_rdata_s = bus.bus_in;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State register, latched request and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            addr_r  <= {BITS{1'b0}};
            wdata_r <= {BITS{1'b0}};
            we_r    <= 1'b0;
            port_r  <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            wdata_r <= wdata_nx_s;
            we_r    <= we_nx_s;
            port_r  <= port_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

`ifdef MEM_BUS_ARB_RR_EN
    // Record the winner of each arbitration so contention alternates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (state_nx_s == ST_ADDR)) begin
            grant_r <= win_data_s;
        end else begin
            grant_r <= grant_r;
        end
    end
`endif

    // Output flops; reset clears every output immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_out_r   <= {BITS{1'b0}};
            f_rdata_r   <= {BITS{1'b0}};
            d_rdata_r   <= {BITS{1'b0}};
            rom_ram_r   <= 1'b0;
            addr_data_r <= 1'b0;
            bus_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            f_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
        end else begin
            bus_out_r   <= bus_out_s;
            f_rdata_r   <= f_rdata_s;
            d_rdata_r   <= d_rdata_s;
            rom_ram_r   <= rom_ram_s;
            addr_data_r <= addr_data_s;
            bus_we_r    <= bus_we_s;
            busy_r      <= busy_s;
            f_ack_r     <= f_ack_s;
            d_ack_r     <= d_ack_s;
        end
    end

    assign bus.bus_out       = bus_out_r;
    assign bus.f_rdata       = f_rdata_r;
    assign bus.d_rdata       = d_rdata_r;
    assign bus.bus_rom_ram   = rom_ram_r;
    assign bus.bus_addr_data = addr_data_r;
    assign bus.bus_we        = bus_we_r;
    assign bus.busy          = busy_r;
    assign bus.f_ack         = f_ack_r;
    assign bus.d_ack         = d_ack_r;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the cpu's single 8-bit multiplexed ROM/RAM bus between two requesters: the instruction-fetch port (ROM) and the data port (RAM load/store).
- Sequences every transfer as an address phase followed by a data phase, with wait states.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the cpu core (fetcher / executor) and the external memory pins.

Parameters:
- BITS, 8, data and address width.
- MIN_WAIT, 0, minimum DATA-phase cycles before bus_ready is honoured (0..15).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- f_req  in  1  fetch request, level; held until f_ack
- f_addr  in  BITS  fetch (ROM) address
- f_ack  out  1  one-cycle pulse; f_rdata valid in the same cycle
- f_rdata  out  BITS  fetched byte, held until the next fetch ack
- d_req  in  1  data request, level; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  BITS  RAM address
- d_wdata  in  BITS  write data
- d_ack  out  1  one-cycle pulse; for reads d_rdata is valid in the same cycle
- d_rdata  out  BITS  read byte, held until the next data read ack
- bus_in  in  BITS  external bus read data
- bus_ready  in  1  memory ready, sampled in DATA only
- bus_out  out  BITS  external bus drive value
- bus_rom_ram  out  1  0 = ROM (fetch), 1 = RAM (data)
- bus_addr_data  out  1  0 = address phase, 1 = data phase
- bus_we  out  1  write strobe, DATA phase only
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ADDR, DATA, ACK.
- All outputs are registered.
- Reset values: every output 0; state IDLE; wait counter 0; grant register = fetch.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any request is high, arbitrate (see Optional Feature), then latch the winner's addr, we and wdata. Fetch is always a read.
  - Go to ADDR.
  - Outputs: bus_out = 0, bus_we = 0.
- ADDR, exactly 1 cycle:
  - bus_out = latched addr; bus_addr_data = 0; bus_rom_ram = winner's port.
  - Go to DATA; clear the wait counter.
- DATA:
  - bus_addr_data = 1.
  - Write: bus_out = wdata, bus_we = 1. Read: bus_out = 0, bus_we = 0.
  - The counter increments each cycle, saturating at MIN_WAIT.
  - Exit when counter == MIN_WAIT and bus_ready == 1. On exit, capture bus_in into the winner's rdata (reads only) and go to ACK.
  - With bus_ready stuck low, DATA is held indefinitely; no timeout.
- ACK, 1 cycle:
  - Winner's ack = 1; bus_we = 0; bus_addr_data = 0; go to IDLE.
  - The requester must drop req before the edge ending ACK. A req still high in IDLE starts a new transfer.
- Latency, read with MIN_WAIT = 0 and bus_ready = 1: req high in cycle 0 → ADDR cycle 1 → DATA cycle 2 → ACK cycle 3. Minimum 4 cycles per transfer, back-to-back.
- Latched request fields are immune to input changes after IDLE; mid-transfer changes to addr, wdata or req are ignored.
- A losing requester is not acked and stays pending until it wins.
- A reset assertion mid-transfer forces all outputs to 0 immediately (asynchronous). No ack is issued and the transfer is abandoned.
- bus_rom_ram keeps its value through ACK and returns to 0 in IDLE.

Optional Feature:
- Macro: MEM_BUS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The grant register records the last winner.
  - When both requests are high in IDLE, the port that did not win last time is granted.
  - A single request always wins.
- Undefined: fixed priority, data port wins whenever d_req is high.
  - The grant register is not used.
  - Fetch can starve under a continuous d_req; this is accepted.

Test Plan:
- Fetch read: reset released, f_req = 1, f_addr = 0x12, bus_in = 0xA5, bus_ready = 1, MIN_WAIT = 0 → bus_out = 0x12 with bus_addr_data = 0, bus_rom_ram = 0 in cycle 1; f_ack pulse in cycle 3 with f_rdata = 0xA5; d_ack stays 0.
- Data write with waits: MIN_WAIT = 2, d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0x3C → ADDR shows 0x40 with bus_rom_ram = 1; DATA shows 0x3C with bus_we = 1 for exactly 3 cycles; d_ack pulses in the next cycle; d_rdata unchanged.
- Ready stall: data read with bus_ready held 0 for 5 DATA cycles, then 1 while bus_in = 0x77 → busy stays 1 throughout; d_ack pulses once; d_rdata = 0x77.
- Contention: f_req and d_req both high continuously → without macro, every grant goes to data; with MEM_BUS_ARB_RR_EN, grants alternate D, F, D, F (first grant D, since the grant register resets to fetch).
- Reset mid-op: assert reset low during DATA of a write → bus_we, busy and bus_out go to 0 before the next clock edge; no ack issued; after release, state is IDLE and a new f_req completes normally.
- Held request: f_req kept high through ACK → a second fetch transfer starts in the following IDLE cycle, so a second f_ack arrives 4 cycles after the first.
